// File: rtl/ndp_out_packer.sv
// Packs pairs of NDP result elements into 32-bit AXI-Stream words through a 2-entry output FIFO.
// Optional per-stream statistics outputs are enabled by defining NDP_OUT_PACKER_STATS_EN.
module ndp_out_packer #(
    parameter int ELEM_W    = 16,
    parameter int PKT_WORDS = 256
) (
    input  logic              axi_aclk,
    input  logic              axi_aresetn,
    input  logic [ELEM_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [31:0]       m_axis_tdata,
    output logic [3:0]        m_axis_tkeep,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready
`ifdef NDP_OUT_PACKER_STATS_EN
    ,
    output logic [31:0]       stat_words,
    output logic [15:0]       stat_packets
`endif
);

    typedef enum logic {S_EMPTY, S_HAVE_LOW} state_t;

    // FIFO entry layout: {tdata[31:0], tkeep[3:0], tlast}
    localparam int ENTRY_W = 37;

    state_t              r_state;
    state_t              w_state_next;
    logic [ELEM_W-1:0]   r_low;
    logic [15:0]         r_pkt_cnt;
    logic [ENTRY_W-1:0]  r_head;
    logic [ENTRY_W-1:0]  r_tail;
    logic [1:0]          r_count;
    logic                r_alive;

    logic                w_accept;
    logic                w_pop;
    logic                w_push;
    logic                w_pkt_end;
    logic [15:0]         w_in16;
    logic [15:0]         w_low16;
    logic [ENTRY_W-1:0]  w_word;

    assign w_in16    = 16'(in_data);
    assign w_low16   = 16'(r_low);
    assign w_pkt_end = (r_pkt_cnt == 16'(PKT_WORDS - 1));

    // in_ready depends only on registered occupancy, never on m_axis_tready
    assign in_ready  = r_alive && (r_count != 2'd2);
    assign w_accept  = in_valid && in_ready;
    assign w_pop     = (r_count != 2'd0) && m_axis_tready;

    assign m_axis_tvalid = (r_count != 2'd0);
    assign m_axis_tdata  = r_head[36:5];
    assign m_axis_tkeep  = r_head[4:1];
    assign m_axis_tlast  = r_head[0];

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_state <= S_EMPTY;
            r_alive <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_alive <= 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        w_word       = '0;
        if (w_accept) begin
            case (r_state)
                S_EMPTY: begin
                    if (in_last) begin
                        w_push = 1'b1;
                        w_word = {16'h0000, w_in16, 4'b0011, 1'b1};
                    end else begin
                        w_state_next = S_HAVE_LOW;
                    end
                end
                S_HAVE_LOW: begin
                    w_push       = 1'b1;
                    w_word       = {w_in16, w_low16, 4'b1111, in_last | w_pkt_end};
                    w_state_next = S_EMPTY;
                end
                default: w_state_next = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_low     <= '0;
            r_pkt_cnt <= '0;
        end else begin
            if (w_accept && (r_state == S_EMPTY) && !in_last)
                r_low <= in_data;
            if (w_push)
                r_pkt_cnt <= w_word[0] ? 16'd0 : r_pkt_cnt + 16'd1;
        end
    end

    // Shift-style FIFO: head is always the oldest word; vacated slots are zeroed
    // so outputs read 0 whenever tvalid is low.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= w_word;
                    else                 r_tail <= w_word;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_tail  <= '0;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_head <= w_word;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= w_word;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef NDP_OUT_PACKER_STATS_EN
    logic [31:0] r_stat_words;
    logic [15:0] r_stat_packets;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_stat_words   <= '0;
            r_stat_packets <= '0;
        end else if (w_pop) begin
            r_stat_words <= r_stat_words + 32'd1;
            if (r_head[0])
                r_stat_packets <= r_stat_packets + 16'd1;
        end
    end

    assign stat_words   = r_stat_words;
    assign stat_packets = r_stat_packets;
`endif

endmodule

// File: tb/tb_ndp_out_packer.sv
// Randomized and directed bench for ndp_out_packer against a queue-based packing model.
// Covers the statistics outputs too when NDP_OUT_PACKER_STATS_EN is defined.
module tb_ndp_out_packer;

    localparam int ELEM_W    = 16;
    localparam int PKT_WORDS = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ELEM_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [31:0]       m_axis_tdata;
    logic [3:0]        m_axis_tkeep;
    logic              m_axis_tlast;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
`ifdef NDP_OUT_PACKER_STATS_EN
    logic [31:0]       stat_words;
    logic [15:0]       stat_packets;
`endif

    ndp_out_packer #(.ELEM_W(ELEM_W), .PKT_WORDS(PKT_WORDS)) dut (
        .axi_aclk      (clk),
        .axi_aresetn   (rst_n),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
`ifdef NDP_OUT_PACKER_STATS_EN
        ,
        .stat_words    (stat_words),
        .stat_packets  (stat_packets)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: words waiting downstream, plus the pending low element.
    logic [36:0] q[$];
    logic [36:0] got[$];
    bit          have_low;
    logic [15:0] low_elem;
    int          pkt_words;
    logic [31:0] m_stat_words;
    logic [15:0] m_stat_packets;
    bit          rdy_seen;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_clear();
        q.delete();
        have_low       = 1'b0;
        low_elem       = '0;
        pkt_words      = 0;
        m_stat_words   = '0;
        m_stat_packets = '0;
    endfunction

    function automatic void model_push(input logic [31:0] data, input logic [3:0] keep, input bit last);
        bit eop;
        pkt_words++;
        eop = last || (pkt_words == PKT_WORDS);
        q.push_back({data, keep, eop});
        if (eop) pkt_words = 0;
    endfunction

    function automatic void model_accept(input logic [15:0] d, input bit l);
        if (!have_low) begin
            if (l) model_push({16'h0000, d}, 4'b0011, 1'b1);
            else begin
                have_low = 1'b1;
                low_elem = d;
            end
        end else begin
            model_push({d, low_elem}, 4'b1111, l);
            have_low = 1'b0;
        end
    endfunction

    task automatic step(input bit v, input logic [15:0] d, input bit l, input bit tr);
        logic [36:0] exp_head;
        bit acc, pop;
        @(negedge clk);
        in_valid = v; in_data = d; in_last = l; m_axis_tready = tr;
        #1;
        exp_head = (q.size() != 0) ? q[0] : 37'd0;
        check_eq("in_ready", 64'(in_ready), 64'(q.size() < 2));
        check_eq("tvalid", 64'(m_axis_tvalid), 64'(q.size() != 0));
        check_eq("head", 64'({m_axis_tdata, m_axis_tkeep, m_axis_tlast}), 64'(exp_head));
        rdy_seen = in_ready;
        acc = v && (q.size() < 2);
        pop = tr && (q.size() != 0);
        if (pop) begin
            got.push_back({m_axis_tdata, m_axis_tkeep, m_axis_tlast});
            m_stat_words++;
            if (q[0][0]) m_stat_packets++;
            void'(q.pop_front());
        end
        if (acc) model_accept(d, l);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_in_ready", 64'(in_ready), 64'd0);
        check_eq("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check_eq("rst_outputs", 64'({m_axis_tdata, m_axis_tkeep, m_axis_tlast}), 64'd0);
        model_clear();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
    endtask

    initial begin
        int base, acc_cnt, k;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; m_axis_tready = 1'b0;
        model_clear();
        #2;
        check_eq("por_in_ready", 64'(in_ready), 64'd0);
        check_eq("por_outputs", 64'({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Two elements forming one complete packet
        step(1'b1, 16'h3C00, 1'b0, 1'b1);
        step(1'b1, 16'h4000, 1'b1, 1'b1);
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        check_eq("r032_word", 64'({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast}),
                 64'({1'b1, 32'h40003C00, 4'hF, 1'b1}));

        // Odd element count: trailing half-word with keep 3
        step(1'b1, 16'h1111, 1'b0, 1'b1);
        step(1'b1, 16'h2222, 1'b0, 1'b1);
        step(1'b1, 16'h3333, 1'b1, 1'b1);
        check_eq("r033_w0", 64'({m_axis_tdata, m_axis_tkeep, m_axis_tlast}), 64'({32'h22221111, 4'hF, 1'b0}));
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        check_eq("r033_w1", 64'({m_axis_tdata, m_axis_tkeep, m_axis_tlast}), 64'({32'h00003333, 4'h3, 1'b1}));
        step(1'b0, 16'h0000, 1'b0, 1'b1);
`ifdef NDP_OUT_PACKER_STATS_EN
        check_eq("r037_words", 64'(stat_words), 64'd3);
        check_eq("r037_packets", 64'(stat_packets), 64'd2);
`endif

        // Eight elements without in_last: PKT_WORDS forces tlast on every 2nd word
        base = got.size();
        for (int i = 0; i < 8; i++) step(1'b1, 16'(16'hA000 + i), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 1'b0, 1'b1);
        check_eq("r034_count", 64'(got.size() - base), 64'd4);
        for (int i = 0; i < 4 && base + i < got.size(); i++)
            check_eq("r034_tlast", 64'(got[base + i][0]), 64'(i % 2));

        // Back-pressure: stream 6 elements with tready low for 10 cycles
        acc_cnt = 0; k = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 16'(16'hB000 + k), 1'b0, 1'b0);
            if (rdy_seen) begin acc_cnt++; k++; end
        end
        check_eq("r035_accepted", 64'(acc_cnt), 64'd4);
        base = got.size();
        for (int i = 0; i < 12; i++) begin
            step(k < 6, 16'(16'hB000 + k), 1'b0, 1'b1);
            if (rdy_seen && k < 6) k++;
        end
        check_eq("r035_drained", 64'(got.size() - base), 64'd3);
        if (got.size() - base == 3)
            check_eq("r035_order", 64'(got[base + 2][36:5]), 64'(32'hB005B004));

        // Reset with a held half and a queued word
        step(1'b1, 16'hC001, 1'b0, 1'b0);
        step(1'b1, 16'hC002, 1'b0, 1'b0);
        step(1'b1, 16'hC003, 1'b0, 1'b0);
        do_reset();
        step(1'b1, 16'hD001, 1'b0, 1'b1);
        step(1'b1, 16'hD002, 1'b1, 1'b1);
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        check_eq("r036_word", 64'({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast}),
                 64'({1'b1, 32'hD002D001, 4'hF, 1'b1}));

        // Randomized traffic with one mid-stream reset
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 5) == 0,
                 $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0000, 1'b0, 1'b1);
`ifdef NDP_OUT_PACKER_STATS_EN
        check_eq("stat_words", 64'(stat_words), 64'(m_stat_words));
        check_eq("stat_packets", 64'(stat_packets), 64'(m_stat_packets));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ndp_out_packer.md
NDP_OUT_PACKER -- requirements
Module: ndp_out_packer

Interface
REQ-001 Parameter ELEM_W, default 16, meaning width of one NDP result element (FP16).
REQ-002 Parameter PKT_WORDS, default 256, meaning maximum 32-bit words per output packet before a forced tlast; legal range 1..65535.
REQ-003 Port axi_aclk  input  1  single clock; all logic rising-edge.
REQ-004 Port axi_aresetn  input  1  asynchronous active-low reset.
REQ-005 Port in_data  input  ELEM_W  result element from NDP_core.
REQ-006 Port in_valid  input  1  in_data valid.
REQ-007 Port in_last  input  1  element is last of the result tile.
REQ-008 Port in_ready  output  1  element accepted when in_valid and in_ready are both high.
REQ-009 Port m_axis_tdata  output  32  packed word to the DMA S2MM stream.
REQ-010 Port m_axis_tkeep  output  4  byte enables.
REQ-011 Port m_axis_tlast  output  1  end of packet.
REQ-012 Port m_axis_tvalid  output  1  word valid.
REQ-013 Port m_axis_tready  input  1  downstream accepts word.

Function
REQ-014 Packer SHALL have two states: EMPTY (no held half) and HAVE_LOW (low half held).
REQ-015 EMPTY + accept, in_last=0 -> store in_data as low half, go HAVE_LOW; no word pushed.
REQ-016 EMPTY + accept, in_last=1 -> push word {16'h0000, in_data}, tkeep=4'b0011, tlast=1; stay EMPTY.
REQ-017 HAVE_LOW + accept -> push word {in_data, low}, tkeep=4'b1111, tlast=in_last OR (packet word count reaches PKT_WORDS); go EMPTY.
REQ-018 Packet word counter SHALL increment per pushed word, reset to 0 after any pushed word with tlast=1.
REQ-019 Tlast forced by PKT_WORDS SHALL NOT discard or alter data; next word starts a new packet.
REQ-020 Pushed words SHALL enter a 2-entry output FIFO; head of FIFO drives m_axis_* directly from registers.
REQ-021 in_ready SHALL be 1 exactly when FIFO holds fewer than 2 entries (registered occupancy, no combinational path from m_axis_tready).
REQ-022 Latency: word pushed on cycle N SHALL present m_axis_tvalid=1 on cycle N+1 when FIFO was empty.
REQ-023 Simultaneous push and pop in one cycle SHALL keep occupancy unchanged and preserve order.
REQ-024 m_axis_tvalid SHALL stay high and m_axis_tdata/tkeep/tlast stable until m_axis_tready is sampled high.
REQ-025 Full FIFO with m_axis_tready=1 SHALL still deassert in_ready that cycle (no bypass).
REQ-026 When tvalid=0, m_axis_tdata, tkeep and tlast SHALL be 0.

Reset
REQ-027 Assertion of axi_aresetn low SHALL immediately clear FIFO, state to EMPTY, held half and packet counter.
REQ-028 Reset values: in_ready=0 while reset asserted, 1 from first clock after release; m_axis_tvalid=0, tdata=0, tkeep=0, tlast=0.
REQ-029 Reset mid-packet SHALL discard any held half and queued words; no partial word emitted after release.

Configuration
REQ-030 Macro NDP_OUT_PACKER_STATS_EN defined: add outputs stat_words (32, count of words handshaked on m_axis) and stat_packets (16, count of handshaked words with tlast=1), both wrapping, cleared by reset.
REQ-031 Macro undefined: stat ports and counters absent; remaining behaviour identical.

Verification
REQ-032 Elements 0x3C00,0x4000 (last on 2nd), tready=1 -> one word 0x40003C00, tkeep=F, tlast=1, tvalid one cycle after 2nd accept.
REQ-033 Three elements 0x1111,0x2222,0x3333 (last on 3rd) -> 0x22221111 keep F tlast 0, then 0x00003333 keep 3 tlast 1.
REQ-034 PKT_WORDS=2, 8 elements no in_last -> 4 words, tlast on words 2 and 4.
REQ-035 tready=0 for 10 cycles, stream 6 elements -> in_ready drops after 4 elements accepted; on tready=1 words drain in order, none lost.
REQ-036 Assert reset after 1 element (HAVE_LOW) and 1 queued word -> after release tvalid=0, next 2 elements form word with no stale data.
REQ-037 STATS_EN defined, run REQ-033 -> stat_words=2, stat_packets=1.
